mac_seq_unit: RTL and testbench
===============================

Name: mac_seq_unit

Overview:
- Parametrised sequential multiply-accumulate engine that computes an N-term unsigned dot product sum(a_i*b_i) from a streamed operand pair interface.
- Successor to the free-running single-enable accumulator. Adds:
  - parametrised operand and accumulator widths;
  - a start/len transaction FSM with a valid/ready handshake and a registered product pipeline stage;
  - a done pulse, a busy flag and sticky overflow detection.
- Sits between the operand-source control FSM and the result/display path.

Parameters:
- A_W, 4, width of operand a.
- B_W, 4, width of operand b.
- ACC_W, 16, accumulator/result width. Must be >= A_W+B_W; elaboration error otherwise.
- CNT_W, 8, width of len and of the remaining-term counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a transaction. Sampled only in IDLE.
- len  in  CNT_W  number of terms, captured on start.
- clear  in  1  zero result and overflow. Honoured only in IDLE.
- a  in  A_W  operand a.
- b  in  B_W  operand b.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair.
- result  out  ACC_W  accumulator value, always visible.
- done  out  1  one-cycle pulse; result is final.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; the accumulation carried out of ACC_W bits.

Behaviour:
- Reset (async, any time): state=IDLE, result=0, overflow=0, done=0, busy=0, in_ready=0, product register and its valid cleared, counter=0. Reset mid-transaction discards the in-flight product. No partial result survives.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 captures len into the counter and sets result=0, overflow=0.
  - len==0 -> DONE; otherwise -> RUN.
  - clear=1 without start zeroes result and overflow. With start and clear together, start takes effect (same zeroing).
- RUN:
  - in_ready=1. A beat transfers when in_valid && in_ready.
  - On a beat: prod <= a*b (A_W+B_W bits, unsigned), prod_vld <= 1, counter decrements.
  - Beat with counter==1 -> DRAIN.
  - Cycles with in_valid=0 do nothing (bubbles allowed, no timeout).
- Accumulate stage, active every cycle in any state: if prod_vld, sum = {1'b0,result} + zero-extended prod, computed in ACC_W+1 bits.
  - result <= sum[ACC_W-1:0].
  - If sum[ACC_W] is set, overflow <= 1 (sticky).
- DRAIN: in_ready=0. Waits one cycle while the last product is added -> DONE.
- DONE: done=1 for exactly one cycle, in_ready=0 -> IDLE.
- Latency: last beat accepted in cycle T; T+1 is DRAIN; done is high in T+2 with the final result.
- For len==0: start in cycle T, done in T+1, result=0.
- start or clear while busy is ignored. len is not re-sampled during a transaction.
- result holds its value in IDLE until the next start, clear or reset.
- Wrap-around: without saturation, result wraps modulo 2^ACC_W.

Optional Feature:
- Macro MAC_SATURATE_EN.
- Defined: on carry-out, result clamps to all-ones (2^ACC_W-1) and stays there for the rest of the transaction; overflow is still set.
- Undefined: result wraps modulo 2^ACC_W; overflow is set.

Decomposition:
- Package mac_pkg:
  - state enum mac_state_t (IDLE, RUN, DRAIN, DONE);
  - default width constants MAC_A_W, MAC_B_W, MAC_ACC_W, MAC_CNT_W.
- One natural sub-module, mac_sat_add: ACC_W adder with carry-out and saturation (under MAC_SATURATE_EN), returning the next result and an overflow indication.
- The FSM and product register stay in mac_seq_unit.

Test Plan:
- Default params, len=3, beats (3,5),(2,7),(15,15) back-to-back -> result=254, overflow=0, done high 2 cycles after the last beat, busy falls the cycle after done.
- len=2, beats (4,4),(1,9) with 3 bubble cycles between them -> result=25, in_ready held at 1 throughout RUN, exactly 2 beats counted.
- ACC_W=10, len=5, five beats of (15,15):
  - macro off -> result=101 (1125 mod 1024), overflow=1;
  - macro on -> result=1023, overflow=1.
- len=0 start -> done in the next cycle, result=0, in_ready never asserted.
- Reset asserted mid-RUN after 1 of 3 beats -> outputs immediately 0, state IDLE. A subsequent start with len=1 and beat (2,3) -> result=6.
- start pulsed during RUN is ignored (the transaction completes with its original len). clear in IDLE after a result of 254 -> result=0, overflow=0.

Source files
------------

// File: rtl/mac_seq_unit_pkg.sv
// mac_pkg: shared state encoding and default widths for the MAC sequencer.
// Revision: 1.0
`default_nettype none

package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  localparam int MAC_A_W   = 4;
  localparam int MAC_B_W   = 4;
  localparam int MAC_ACC_W = 16;
  localparam int MAC_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/mac_seq_unit_if.sv
// mac_seq_unit_if: control, operand stream and result bundle of the MAC sequencer.
// Revision: 1.0
`default_nettype none

interface mac_seq_unit_if
  import mac_pkg::*;
#(
  parameter int A_W   = MAC_A_W,
  parameter int B_W   = MAC_B_W,
  parameter int ACC_W = MAC_ACC_W,
  parameter int CNT_W = MAC_CNT_W
) ();

  logic             start;
  logic [CNT_W-1:0] len;
  logic             clear;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] result;
  logic             done;
  logic             busy;
  logic             overflow;

  modport master (
    output start, len, clear, a, b, in_valid,
    input  in_ready, result, done, busy, overflow
  );

  modport slave (
    input  start, len, clear, a, b, in_valid,
    output in_ready, result, done, busy, overflow
  );

endinterface

`default_nettype wire

// File: rtl/mac_seq_unit_sat_add.sv
// mac_sat_add: accumulator adder with carry-out; clamps to all-ones when
// MAC_SATURATE_EN is defined, otherwise wraps.  Revision: 1.0
`default_nettype none

module mac_sat_add #(
  parameter int ACC_W = 16,
  parameter int P_W   = 8
) (
  input  wire logic [ACC_W-1:0] i_acc,
  input  wire logic [P_W-1:0]   i_prod,
  output logic      [ACC_W-1:0] o_sum,
  output logic                  o_carry
);

  logic [ACC_W:0] w_sum;

  assign w_sum   = {1'b0, i_acc} + {{(ACC_W + 1 - P_W){1'b0}}, i_prod};
  assign o_carry = w_sum[ACC_W];

`ifdef MAC_SATURATE_EN
  // Once clamped, any further add carries again, so the clamp holds.
  assign o_sum = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign o_sum = w_sum[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/mac_seq_unit.sv
// mac_seq_unit: start/len driven N-term unsigned dot-product engine with a
// registered product stage. Optional MAC_SATURATE_EN clamps result. Revision: 1.0
`default_nettype none

module mac_seq_unit
  import mac_pkg::*;
#(
  parameter int A_W   = MAC_A_W,
  parameter int B_W   = MAC_B_W,
  parameter int ACC_W = MAC_ACC_W,
  parameter int CNT_W = MAC_CNT_W
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mac_seq_unit_if.slave bus
);

  localparam int P_W = A_W + B_W;

  generate
    if (ACC_W < P_W) begin : g_bad_acc_w
      $error("mac_seq_unit: ACC_W must be >= A_W+B_W");
    end
  endgenerate

  mac_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [P_W-1:0]   r_prod;
  logic             r_prod_vld;
  logic [ACC_W-1:0] r_result;
  logic             r_overflow;
  logic             r_done;
  logic             r_busy;
  logic             r_in_ready;

  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  mac_sat_add #(
    .ACC_W (ACC_W),
    .P_W   (P_W)
  ) u_add (
    .i_acc   (r_result),
    .i_prod  (r_prod),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_prod_vld <= 1'b0;

      if (r_prod_vld) begin
        r_result <= w_sum;
        if (w_carry) r_overflow <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          // No product is ever pending in IDLE, so the zeroing below is safe.
          if (bus.start) begin
            r_cnt      <= bus.len;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= RUN;
              r_in_ready <= 1'b1;
            end
          end else if (bus.clear) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
          end
        end
        RUN: begin
          if (bus.in_valid && r_in_ready) begin
            r_prod     <= P_W'(bus.a) * P_W'(bus.b);
            r_prod_vld <= 1'b1;
            r_cnt      <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.result   = r_result;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_unit.sv
// tb_mac_seq_unit: drives a 16-bit and a 10-bit accumulator instance in lockstep
// and checks both against a dot-product model.  Revision: 1.0
`default_nettype none

module tb_mac_seq_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic       clear = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       in_valid = 1'b0;

  int total = 0;
  int bad = 0;

  int qa[$];
  int qb[$];
  int qbub[$];

  always #5 clk = ~clk;

  mac_seq_unit_if #(.ACC_W(16)) if16 ();
  mac_seq_unit_if #(.ACC_W(10)) if10 ();

  assign if16.start = start;    assign if10.start = start;
  assign if16.len = len;        assign if10.len = len;
  assign if16.clear = clear;    assign if10.clear = clear;
  assign if16.a = a;            assign if10.a = a;
  assign if16.b = b;            assign if10.b = b;
  assign if16.in_valid = in_valid;
  assign if10.in_valid = in_valid;

  mac_seq_unit #(.ACC_W(16)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));
  mac_seq_unit #(.ACC_W(10)) u_dut10 (.clk(clk), .reset(reset), .bus(if10));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected final result for a true (unbounded) dot product s in w bits.
  function automatic logic [31:0] mdl_res(input longint s, input int w);
    longint m = longint'(1) << w;
`ifdef MAC_SATURATE_EN
    return (s >= m) ? 32'(m - 1) : 32'(s);
`else
    return 32'(s % m);
`endif
  endfunction

  function automatic logic [31:0] mdl_ovf(input longint s, input int w);
    return (s >= (longint'(1) << w)) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_res16"}, 32'(if16.result), 0);
    chk({tag, "_res10"}, 32'(if10.result), 0);
    chk({tag, "_ovf10"}, 32'(if10.overflow), 0);
    chk({tag, "_busy"}, 32'(if16.busy), 0);
    chk({tag, "_rdy"}, 32'(if16.in_ready), 0);
    chk({tag, "_done"}, 32'(if16.done), 0);
  endtask

  // Runs one transaction from qa/qb with qbub bubbles ahead of each beat.
  task automatic run_txn(input string tag, input bit spur);
    int n = qa.size();
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(qa[i] * qb[i]);
    @(posedge clk); #1 start = 1'b1; len = 8'(n);
    @(posedge clk); #1 start = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      chk({tag, "_z_done"}, 32'(if16.done), 1);
      chk({tag, "_z_rdy"}, 32'(if16.in_ready), 0);
      chk({tag, "_z_res"}, 32'(if16.result), 0);
      @(negedge clk);
      chk({tag, "_z_done_end"}, 32'(if16.done), 0);
      chk({tag, "_z_busy_end"}, 32'(if16.busy), 0);
      chk({tag, "_z_rdy_end"}, 32'(if16.in_ready), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < qbub[i]; k++) begin
        in_valid = 1'b0;
        if (spur) begin start = 1'b1; len = 8'd1; end
        @(negedge clk);
        chk({tag, "_bub_rdy"}, 32'(if16.in_ready), 1);
        @(posedge clk); #1 start = 1'b0;
      end
      a = 4'(qa[i]); b = 4'(qb[i]); in_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_beat_rdy"}, 32'(if16.in_ready), 1);
      chk({tag, "_beat_done"}, 32'(if16.done), 0);
      @(posedge clk); #1 in_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_drain_rdy"}, 32'(if16.in_ready), 0);
    chk({tag, "_drain_done"}, 32'(if16.done), 0);
    chk({tag, "_drain_busy"}, 32'(if16.busy), 1);
    @(negedge clk);
    chk({tag, "_done"}, 32'(if16.done), 1);
    chk({tag, "_res16"}, 32'(if16.result), mdl_res(s, 16));
    chk({tag, "_ovf16"}, 32'(if16.overflow), mdl_ovf(s, 16));
    chk({tag, "_res10"}, 32'(if10.result), mdl_res(s, 10));
    chk({tag, "_ovf10"}, 32'(if10.overflow), mdl_ovf(s, 10));
    @(negedge clk);
    chk({tag, "_done_end"}, 32'(if16.done), 0);
    chk({tag, "_busy_end"}, 32'(if16.busy), 0);
    chk({tag, "_hold16"}, 32'(if16.result), mdl_res(s, 16));
  endtask

  task automatic pulse_clear(input string tag);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check_idle_zero(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    #2 reset = 1'b0;

    qa = '{3, 2, 15}; qb = '{5, 7, 15}; qbub = '{0, 0, 0};
    run_txn("b2b", 1'b0);
    pulse_clear("clr254");

    qa = '{4, 1}; qb = '{4, 9}; qbub = '{0, 3};
    run_txn("bubble", 1'b0);

    qa = '{15, 15, 15, 15, 15}; qb = '{15, 15, 15, 15, 15}; qbub = '{0, 0, 0, 0, 0};
    run_txn("ovf", 1'b0);
    pulse_clear("clrovf");

    qa.delete(); qb.delete(); qbub.delete();
    run_txn("len0", 1'b0);

    qa = '{6, 9, 2}; qb = '{7, 3, 11}; qbub = '{1, 2, 1};
    run_txn("spur", 1'b1);

    // Asynchronous reset after one of three beats has been accumulated.
    @(posedge clk); #1 start = 1'b1; len = 8'd3;
    @(posedge clk); #1 start = 1'b0; a = 4'd3; b = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_partial", 32'(if16.result), 15);
    #2 reset = 1'b1;
    #1 check_idle_zero("mid_rst");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_idle_zero("post_rst");
    qa = '{2}; qb = '{3}; qbub = '{0};
    run_txn("after_rst", 1'b0);

    for (int t = 0; t < 10; t++) begin
      int n = int'($urandom_range(1, 8));
      qa.delete(); qb.delete(); qbub.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(int'($urandom_range(0, 15)));
        qb.push_back(int'($urandom_range(0, 15)));
        qbub.push_back(int'($urandom_range(0, 2)));
      end
      run_txn($sformatf("rnd%0d", t), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
